// File: rtl/wallace_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mult_pipe
// Brief    : 3-stage pipelined Baugh-Wooley / Wallace-tree multiplier with
//            valid/ready handshakes, per-transaction sign mode and sideband tag.
// Revision : 1.0 - initial release
// ============================================================================
module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int C_PW = 2 * WIDTH;
  localparam int C_NR = WIDTH + 1;  // WIDTH partial-product rows plus one constant row

  function automatic int reduce_levels(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int C_LEVELS = reduce_levels(C_NR);

  logic              en;
  logic              v1_q, v2_q, out_valid_q;
  logic [C_PW-1:0]   pp_d  [C_NR];
  logic [C_PW-1:0]   pp_q  [C_NR];
  logic [TAG_W-1:0]  tag1_q, tag2_q, out_tag_q;
  logic [C_PW-1:0]   sum_d, cry_d, sum_q, cry_q;
  logic [C_PW-1:0]   p_d, p_q;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Signed mode inverts the bits pairing exactly one sign bit with a magnitude
  // bit, and adds the correction constants 2^WIDTH and 2^(2*WIDTH-1).
  always_comb begin
    for (int r = 0; r < C_NR; r++) pp_d[r] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][i+j] = (a[j] & b[i]) ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    pp_d[WIDTH][WIDTH]  = in_signed;
    pp_d[WIDTH][C_PW-1] = in_signed;
  end

  // Wallace reduction: each level compresses row triples with full-adder
  // columns (sum, carry<<1); leftover rows pass through to the next level.
  always_comb begin
    logic [C_PW-1:0] row_cur [C_NR];
    logic [C_PW-1:0] row_nxt [C_NR];
    int n;
    int m;
    row_cur = pp_q;
    n       = C_NR;
    m       = 0;
    for (int l = 0; l < C_LEVELS; l++) begin
      for (int r = 0; r < C_NR; r++) row_nxt[r] = '0;
      m = 0;
      for (int g = 0; g < C_NR / 3; g++) begin
        if (3 * g + 2 < n) begin
          row_nxt[m]   = row_cur[3*g] ^ row_cur[3*g+1] ^ row_cur[3*g+2];
          row_nxt[m+1] = ((row_cur[3*g] & row_cur[3*g+1]) |
                          (row_cur[3*g] & row_cur[3*g+2]) |
                          (row_cur[3*g+1] & row_cur[3*g+2])) << 1;
          m = m + 2;
        end
      end
      for (int r = 0; r < C_NR; r++) begin
        if (r >= 3 * (n / 3) && r < n) begin
          row_nxt[m] = row_cur[r];
          m = m + 1;
        end
      end
      row_cur = row_nxt;
      n       = m;
    end
    sum_d = row_cur[0];
    cry_d = row_cur[1];
  end

  assign p_d = sum_q + cry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        p_q       <= p_d;
        out_tag_q <= tag2_q;
      end
    end
  end

  // Datapath registers only load behind a valid flag, so bubbles never disturb them.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      pp_q   <= pp_d;
      tag1_q <= in_tag;
    end
    if (en && v1_q) begin
      sum_q  <= sum_d;
      cry_q  <= cry_d;
      tag2_q <= tag1_q;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign out_tag   = out_tag_q;

endmodule
`default_nettype wire
